// File: rtl/attack_manager.sv
// attack_manager
//   Scores each piece lock (lines, T-spin, combo, back-to-back), cancels the
//   resulting attack against pending incoming garbage, offers any remainder
//   to the versus link and releases pending garbage to the playfield after a
//   lock that clears no lines. It also keeps the per-game display counters.
//
// Ports
//   clk, rst_l            clock, asynchronous active-low reset
//   game_start            synchronous clear of all state (highest priority)
//   lock, tspin           one-cycle lock pulse, T-spin qualifier
//   lines_full[ROWS]      per-row full flags, sampled with lock
//   garbage_in_valid/count  incoming opponent garbage, accepted any cycle
//   send_valid/ready/count  outgoing attack handshake
//   garbage_apply/_count  one-cycle pulse of rows for the playfield to insert
//   pending_garbage       rows queued against this player
//   lines_cleared/sent    game totals (wrap)
//   combo_count, b2b_active  scoring state for display
//   busy, lock_overrun    FSM not idle; sticky dropped-lock flag
//   dbg_state             current FSM state
//
// Handshake: send_valid is raised with send_count and both hold steady until
// a cycle where send_valid && send_ready; that cycle is the transfer, and
// send_valid drops on the following edge.
module attack_manager #(
  parameter int ROWS      = 20,
  parameter int CNT_W     = 10,
  parameter int COMBO_W   = 5,
  parameter int PEND_W    = 5,
  parameter int APPLY_MAX = 4,
  parameter int B2B_BONUS = 1
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               game_start,
  input  logic               lock,
  input  logic               tspin,
  input  logic               lines_full [ROWS],
  input  logic               garbage_in_valid,
  input  logic [PEND_W-1:0]  garbage_in_count,
  output logic               send_valid,
  input  logic               send_ready,
  output logic [4:0]         send_count,
  output logic               garbage_apply,
  output logic [2:0]         garbage_apply_count,
  output logic [PEND_W-1:0]  pending_garbage,
  output logic [CNT_W-1:0]   lines_cleared,
  output logic [CNT_W-1:0]   lines_sent,
  output logic [COMBO_W-1:0] combo_count,
  output logic               b2b_active,
  output logic               busy,
  output logic               lock_overrun,
  output logic [2:0]         dbg_state
);

  localparam int N_W = $clog2(ROWS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL, S_CANCEL, S_SEND, S_APPLY
  } state_t;

  state_t             r_state;
  logic [N_W-1:0]     r_n;
  logic               r_tspin;
  logic [4:0]         r_attack;
  logic               r_prev_clear;
  logic [COMBO_W-1:0] r_combo;
  logic               r_b2b;
  logic [PEND_W-1:0]  r_pending;
  logic [CNT_W-1:0]   r_lines_cleared;
  logic [CNT_W-1:0]   r_lines_sent;
  logic               r_send_valid;
  logic [4:0]         r_send_count;
  logic               r_apply;
  logic [2:0]         r_apply_cnt;
  logic               r_overrun;

  logic [N_W-1:0]     w_popcnt;
  logic [4:0]         w_base;
  logic               w_difficult;
  logic [COMBO_W-1:0] w_combo_new;
  logic [31:0]        w_combo32;
  logic [4:0]         w_cbonus;
  logic [4:0]         w_b2b_bonus;
  logic [4:0]         w_attack;
  logic [PEND_W-1:0]  w_cancel;
  logic [4:0]         w_remainder;
  logic [2:0]         w_apply_cnt;
  logic [PEND_W-1:0]  w_sub;
  logic [PEND_W-1:0]  w_after_sub;
  logic [PEND_W-1:0]  w_gin;
  logic [PEND_W:0]    w_sum;
  logic [PEND_W-1:0]  w_pend_next;

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < ROWS; i++) w_popcnt = w_popcnt + N_W'(lines_full[i]);
  end

  always_comb begin
    w_base = 5'd0;
    if (r_tspin) begin
      case (r_n)
        N_W'(0): w_base = 5'd0;
        N_W'(1): w_base = 5'd2;
        N_W'(2): w_base = 5'd4;
        default: w_base = 5'd6;
      endcase
    end else begin
      case (r_n)
        N_W'(0), N_W'(1): w_base = 5'd0;
        N_W'(2):          w_base = 5'd1;
        N_W'(3):          w_base = 5'd2;
        default:          w_base = 5'd4;
      endcase
    end
  end

  assign w_difficult = (r_n == N_W'(4)) || (r_tspin && (r_n != '0));

  // Combo only advances when the previous accepted lock also cleared lines.
  assign w_combo_new = r_prev_clear ? ((r_combo == '1) ? r_combo : r_combo + 1'b1) : '0;
  assign w_combo32   = 32'(w_combo_new);

  always_comb begin
    w_cbonus = 5'd0;
    if      (w_combo32 >= 32'd10) w_cbonus = 5'd5;
    else if (w_combo32 >= 32'd7)  w_cbonus = 5'd4;
    else if (w_combo32 >= 32'd5)  w_cbonus = 5'd3;
    else if (w_combo32 >= 32'd3)  w_cbonus = 5'd2;
    else if (w_combo32 >= 32'd1)  w_cbonus = 5'd1;
  end

  assign w_b2b_bonus = (w_difficult && r_b2b) ? 5'(B2B_BONUS) : 5'd0;
  assign w_attack    = w_base + w_cbonus + w_b2b_bonus;

  assign w_cancel    = (32'(r_attack) > 32'(r_pending)) ? r_pending : PEND_W'(r_attack);
  assign w_remainder = r_attack - 5'(w_cancel);
  assign w_apply_cnt = (32'(r_pending) > 32'(APPLY_MAX)) ? 3'(APPLY_MAX) : 3'(r_pending);

  // Removals never exceed the registered count, so subtract first, then add
  // the incoming rows with saturation.
  always_comb begin
    w_sub = '0;
    if (r_state == S_CANCEL)     w_sub = w_cancel;
    else if (r_state == S_APPLY) w_sub = PEND_W'(r_apply_cnt);
  end
  assign w_after_sub = r_pending - w_sub;
  assign w_gin       = garbage_in_valid ? garbage_in_count : '0;
  assign w_sum       = {1'b0, w_after_sub} + {1'b0, w_gin};
  assign w_pend_next = w_sum[PEND_W] ? '1 : w_sum[PEND_W-1:0];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= S_IDLE;         r_n <= '0;             r_tspin <= 1'b0;
      r_attack <= '0;            r_prev_clear <= 1'b0;  r_combo <= '0;
      r_b2b <= 1'b0;             r_pending <= '0;       r_lines_cleared <= '0;
      r_lines_sent <= '0;        r_send_valid <= 1'b0;  r_send_count <= '0;
      r_apply <= 1'b0;           r_apply_cnt <= '0;     r_overrun <= 1'b0;
    end else if (game_start) begin
      r_state <= S_IDLE;         r_n <= '0;             r_tspin <= 1'b0;
      r_attack <= '0;            r_prev_clear <= 1'b0;  r_combo <= '0;
      r_b2b <= 1'b0;             r_pending <= '0;       r_lines_cleared <= '0;
      r_lines_sent <= '0;        r_send_valid <= 1'b0;  r_send_count <= '0;
      r_apply <= 1'b0;           r_apply_cnt <= '0;     r_overrun <= 1'b0;
    end else begin
      r_pending <= w_pend_next;
      r_apply   <= 1'b0;
      if (lock && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (lock) begin
            r_n     <= w_popcnt;
            r_tspin <= tspin;
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (r_n != '0) begin
            r_lines_cleared <= r_lines_cleared + CNT_W'(r_n);
            r_combo         <= w_combo_new;
            r_b2b           <= w_difficult;
            r_attack        <= w_attack;
            r_prev_clear    <= 1'b1;
            r_state         <= S_CANCEL;
          end else begin
            r_combo      <= '0;
            r_prev_clear <= 1'b0;
            if (r_pending != '0) begin
              r_apply     <= 1'b1;
              r_apply_cnt <= w_apply_cnt;
              r_state     <= S_APPLY;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_CANCEL: begin
          if (w_remainder != '0) begin
            r_send_valid <= 1'b1;
            r_send_count <= w_remainder;
            r_state      <= S_SEND;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (send_ready) begin
            r_lines_sent <= r_lines_sent + CNT_W'(r_send_count);
            r_send_valid <= 1'b0;
            r_send_count <= '0;
            r_state      <= S_IDLE;
          end
        end
        S_APPLY: begin
          r_apply_cnt <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign send_valid          = r_send_valid;
  assign send_count          = r_send_count;
  assign garbage_apply       = r_apply;
  assign garbage_apply_count = r_apply_cnt;
  assign pending_garbage     = r_pending;
  assign lines_cleared       = r_lines_cleared;
  assign lines_sent          = r_lines_sent;
  assign combo_count         = r_combo;
  assign b2b_active          = r_b2b;
  assign busy                = (r_state != S_IDLE);
  assign lock_overrun        = r_overrun;
  assign dbg_state           = r_state;

endmodule

// File: tb/tb_attack_manager.sv
module tb_attack_manager;

  localparam int ROWS = 20;

  logic       clk;
  logic       rst_l;
  logic       game_start;
  logic       lock;
  logic       tspin;
  logic       lines_full [ROWS];
  logic       garbage_in_valid;
  logic [4:0] garbage_in_count;
  logic       send_valid;
  logic       send_ready;
  logic [4:0] send_count;
  logic       garbage_apply;
  logic [2:0] garbage_apply_count;
  logic [4:0] pending_garbage;
  logic [9:0] lines_cleared;
  logic [9:0] lines_sent;
  logic [4:0] combo_count;
  logic       b2b_active;
  logic       busy;
  logic       lock_overrun;
  logic [2:0] dbg_state;

  attack_manager dut (
    .clk(clk), .rst_l(rst_l), .game_start(game_start), .lock(lock), .tspin(tspin),
    .lines_full(lines_full), .garbage_in_valid(garbage_in_valid),
    .garbage_in_count(garbage_in_count), .send_valid(send_valid),
    .send_ready(send_ready), .send_count(send_count), .garbage_apply(garbage_apply),
    .garbage_apply_count(garbage_apply_count), .pending_garbage(pending_garbage),
    .lines_cleared(lines_cleared), .lines_sent(lines_sent), .combo_count(combo_count),
    .b2b_active(b2b_active), .busy(busy), .lock_overrun(lock_overrun),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] send_exp_q[$];
  logic [2:0] apply_exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int base_norm[5] = '{0, 0, 1, 2, 4};
  int base_ts[4]   = '{0, 2, 4, 6};
  int m_pending, m_lines, m_sent, m_combo, m_b2b, m_prev, m_overrun;

  function automatic int cbonus(input int c);
    if (c == 0) return 0;
    if (c >= 10) return 5;
    if (c >= 7) return 4;
    return (c + 1) / 2;
  endfunction

  function automatic int sat31(input int v);
    return (v > 31) ? 31 : v;
  endfunction

  task automatic model_reset();
    m_pending = 0; m_lines = 0; m_sent = 0; m_combo = 0;
    m_b2b = 0; m_prev = 0; m_overrun = 0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic       prev_stall;
    logic [4:0] prev_cnt;
    logic [4:0] e;
    prev_stall = 1'b0;
    prev_cnt   = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_l && !game_start) begin
        if (send_valid && prev_stall) chk("send_count_stable", send_count, prev_cnt);
        if (send_valid && send_ready) begin
          if (send_exp_q.size() == 0) chk("send_unexpected", 1, 0);
          else begin
            e = send_exp_q.pop_front();
            chk("send_count", send_count, e);
          end
        end
        if (garbage_apply) begin
          if (apply_exp_q.size() == 0) chk("apply_unexpected", 1, 0);
          else begin
            e = 5'(apply_exp_q.pop_front());
            chk("apply_count", garbage_apply_count, e);
          end
        end
        prev_stall = send_valid && !send_ready;
        prev_cnt   = send_count;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_status(input string tag);
    chk({tag, "_lines_cleared"}, lines_cleared, m_lines);
    chk({tag, "_lines_sent"}, lines_sent, m_sent);
    chk({tag, "_combo"}, combo_count, m_combo);
    chk({tag, "_b2b"}, b2b_active, m_b2b);
    chk({tag, "_pending"}, pending_garbage, m_pending);
    chk({tag, "_overrun"}, lock_overrun, m_overrun);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_send_valid"}, send_valid, 0);
    chk({tag, "_apply"}, garbage_apply, 0);
  endtask

  task automatic inject(input int g);
    @(negedge clk);
    garbage_in_valid = 1'b1;
    garbage_in_count = 5'(g);
    @(negedge clk);
    garbage_in_valid = 1'b0;
    garbage_in_count = '0;
    m_pending = sat31(m_pending + g);
  endtask

  task automatic do_game_start();
    @(negedge clk);
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
    model_reset();
    check_status("gs");
  endtask

  // abort_mode: 0 normal, 1 game_start (with a lock) during SEND, 2 reset during SEND
  task automatic do_lock(input int n, input bit ts, input int stall, input bit ovr,
                         input int apply_g, input int abort_mode);
    int cnt, r, atk, c, a, rem, g;
    bit diff, exp_send, exp_apply;
    cnt = 0; rem = 0; exp_send = 0; exp_apply = 0;
    for (int i = 0; i < ROWS; i++) lines_full[i] = 1'b0;
    while (cnt < n) begin
      r = $urandom_range(ROWS - 1);
      if (!lines_full[r]) begin lines_full[r] = 1'b1; cnt++; end
    end
    if (n > 0) begin
      m_lines = (m_lines + n) % 1024;
      m_combo = m_prev ? ((m_combo < 31) ? m_combo + 1 : 31) : 0;
      diff = (n == 4) || ts;
      atk = (ts ? base_ts[n] : base_norm[n]) + cbonus(m_combo) + ((diff && m_b2b) ? 1 : 0);
      m_b2b = diff ? 1 : 0;
      m_prev = 1;
      c = (atk < m_pending) ? atk : m_pending;
      m_pending -= c;
      rem = atk - c;
      if (rem > 0) begin exp_send = 1; send_exp_q.push_back(5'(rem)); end
    end else begin
      m_combo = 0;
      m_prev = 0;
      if (m_pending > 0) begin
        a = (m_pending < 4) ? m_pending : 4;
        exp_apply = 1;
        apply_exp_q.push_back(3'(a));
        m_pending -= a;
      end
    end

    @(negedge clk);
    lock = 1'b1; tspin = ts;
    @(negedge clk);
    lock = 1'b0; tspin = 1'b0;
    for (int i = 0; i < ROWS; i++) lines_full[i] = 1'b0;
    chk("busy_c1", busy, 1);

    if (exp_apply) begin
      @(negedge clk);
      chk("apply_c2", garbage_apply, 1);
      if (apply_g > 0) begin
        garbage_in_valid = 1'b1;
        garbage_in_count = 5'(apply_g);
        m_pending = sat31(m_pending + apply_g);
      end
      @(negedge clk);
      garbage_in_valid = 1'b0;
      garbage_in_count = '0;
      chk("busy_c3_apply", busy, 0);
    end else if (exp_send) begin
      @(negedge clk);
      chk("valid_c2", send_valid, 0);
      @(negedge clk);
      chk("valid_c3", send_valid, 1);
      if (abort_mode == 1) begin
        game_start = 1'b1;
        lock = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
        lock = 1'b0;
        void'(send_exp_q.pop_back());
        model_reset();
        check_status("abort_gs");
        return;
      end
      if (abort_mode == 2) begin
        rst_l = 1'b0;
        #1;
        chk("rst_drops_valid", send_valid, 0);
        void'(send_exp_q.pop_back());
        model_reset();
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        check_status("abort_rst");
        return;
      end
      for (int k = 0; k < stall; k++) begin
        if (ovr && k == stall / 2) begin
          lock = 1'b1;
          m_overrun = 1;
        end
        if ($urandom_range(0, 3) == 0) begin
          g = $urandom_range(1, 8);
          garbage_in_valid = 1'b1;
          garbage_in_count = 5'(g);
          m_pending = sat31(m_pending + g);
        end
        @(negedge clk);
        lock = 1'b0;
        garbage_in_valid = 1'b0;
        garbage_in_count = '0;
      end
      send_ready = 1'b1;
      @(negedge clk);
      send_ready = 1'b0;
      m_sent = (m_sent + rem) % 1024;
      chk("busy_after_hs", busy, 0);
    end else begin
      @(negedge clk);
      @(negedge clk);
      chk("busy_c3", busy, 0);
    end
    check_status("lock");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit ts;
    rst_l = 1'b0; game_start = 1'b0; lock = 1'b0; tspin = 1'b0;
    garbage_in_valid = 1'b0; garbage_in_count = '0; send_ready = 1'b0;
    for (int i = 0; i < ROWS; i++) lines_full[i] = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    check_status("reset");

    // Two back-to-back tetrises from a clean game.
    do_lock(4, 0, 0, 0, 0, 0);
    chk("tetris1_sent", lines_sent, 4);
    chk("tetris1_combo", combo_count, 0);
    chk("tetris1_b2b", b2b_active, 1);
    do_lock(4, 0, 0, 0, 0, 0);
    chk("tetris2_combo", combo_count, 1);
    chk("tetris2_sent", lines_sent, 10);

    // T-spin double fully cancelled by pending garbage, then apply the rest.
    do_game_start();
    inject(5);
    do_lock(2, 1, 0, 0, 0, 0);
    chk("tsd_pending", pending_garbage, 1);
    do_lock(0, 0, 0, 0, 0, 0);
    chk("apply1_pending", pending_garbage, 0);

    // Apply capped at four with garbage arriving in the apply cycle.
    inject(7);
    do_lock(0, 0, 0, 0, 2, 0);
    chk("apply_cap_pending", pending_garbage, 5);

    // Long stall with a dropped lock, then game_start mid-send.
    do_game_start();
    do_lock(4, 0, 10, 1, 0, 0);
    chk("overrun_set", lock_overrun, 1);
    do_lock(4, 0, 0, 0, 0, 1);

    // Pending saturation.
    inject(31);
    inject(31);
    chk("pending_sat", pending_garbage, 31);

    // Long tetris run: combo saturates, totals wrap.
    do_game_start();
    for (int i = 0; i < 256; i++) do_lock(4, 0, $urandom_range(0, 2), 0, 0, 0);
    chk("combo_sat", combo_count, 31);
    chk("lines_wrap", lines_cleared, 0);

    // Randomised play.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) inject($urandom_range(1, 12));
      n  = $urandom_range(0, 4);
      ts = (n <= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_lock(n, ts, $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
              $urandom_range(0, 3), 0);
    end

    // Asynchronous reset during SEND.
    do_game_start();
    do_lock(4, 0, 0, 0, 0, 2);

    repeat (3) @(negedge clk);
    chk("send_q_empty", send_exp_q.size(), 0);
    chk("apply_q_empty", apply_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/attack_manager.md
# attack_manager

Parametrised next-generation lines/attack manager that sits between the playfield lock logic and the versus link. On each piece lock it scores the clear (lines, T-spin, combo, back-to-back) and cancels outgoing attack against pending incoming garbage. It sends any remainder to the opponent over a valid/ready handshake, and releases pending garbage to the playfield when a lock clears no lines. It also keeps the game's lines-cleared, lines-sent, combo and B2B state for display.

## Interface
- ROWS, 20, playfield rows scanned for full lines
- CNT_W, 10, width of lines_cleared / lines_sent totals
- COMBO_W, 5, combo counter width
- PEND_W, 5, pending-garbage counter width
- APPLY_MAX, 4, max garbage rows released to playfield per lock
- B2B_BONUS, 1, extra lines for a back-to-back difficult clear

- clk  in  1  system clock
- rst_l  in  1  asynchronous active-low reset
- game_start  in  1  synchronous clear of all state; highest priority
- lock  in  1  one-cycle pulse, piece locked this cycle
- tspin  in  1  qualifies lock as T-spin, sampled with lock
- lines_full  in  ROWS×1 (unpacked)  per-row full flags, sampled with lock
- garbage_in_valid  in  1  opponent garbage arrives this cycle
- garbage_in_count  in  PEND_W  rows of incoming garbage
- send_valid  out  1  outgoing attack available
- send_ready  in  1  link accepts attack
- send_count  out  5  attack rows offered; stable while send_valid && !send_ready
- garbage_apply  out  1  one-cycle pulse, playfield inserts garbage rows
- garbage_apply_count  out  3  rows to insert with garbage_apply
- pending_garbage  out  PEND_W  rows queued against this player
- lines_cleared  out  CNT_W  total lines cleared this game
- lines_sent  out  CNT_W  total attack rows handed to the link
- combo_count  out  COMBO_W  current combo
- b2b_active  out  1  last non-zero clear was difficult
- busy  out  1  FSM not in IDLE
- lock_overrun  out  1  sticky; a lock arrived while busy

## Operation
- FSM states: IDLE, EVAL, CANCEL, SEND, APPLY.
- IDLE: on lock, latch n = popcount(lines_full) and tspin, then go to EVAL.
- A lock received while busy is dropped and sets lock_overrun.
- Base attack:
  - Non-T-spin: n = 0/1/2/3/4 gives 0/0/1/2/4.
  - T-spin: n = 0/1/2/3 gives 0/2/4/6.
- A difficult clear is n==4, or tspin && n>0.
- EVAL, one cycle, when n>0:
  - lines_cleared += n.
  - combo_count += 1, saturating at 2^COMBO_W−1, but only if the previous lock also cleared lines; otherwise combo_count stays 0.
  - Combo bonus from the updated combo_count: 0→0, 1–2→1, 3–4→2, 5–6→3, 7–9→4, ≥10→5.
  - B2B bonus is B2B_BONUS when the clear is difficult and b2b_active was 1 before this lock.
  - b2b_active is then set to 1 if the clear is difficult, else 0.
  - attack = base + combo bonus + B2B bonus. Go to CANCEL.
- EVAL, one cycle, when n==0:
  - combo_count goes to 0; b2b_active is unchanged.
  - If pending_garbage>0, go to APPLY; else go to IDLE.
- CANCEL: c = min(attack, pending_garbage); pending_garbage −= c; remainder = attack − c. If remainder>0, go to SEND; else go to IDLE.
- SEND:
  - send_valid=1 and send_count=remainder.
  - On send_valid && send_ready: lines_sent += send_count, then go to IDLE.
- APPLY: pulse garbage_apply with count = min(pending_garbage, APPLY_MAX); subtract that count from pending; go to IDLE.
- Incoming garbage is accepted in any state.
  - pending_next = sat(pending − cancel − apply + (garbage_in_valid ? garbage_in_count : 0)).
  - The subtraction is applied to the registered value first; saturation is at 2^PEND_W−1.
- lines_cleared and lines_sent wrap modulo 2^CNT_W.
- game_start clears all counters, b2b_active, lock_overrun and pending_garbage, forces IDLE and drops send_valid the next cycle.
- A lock in the same cycle as game_start is ignored.

## Timing
- Reset values:
  - All outputs 0 and FSM in IDLE; send_valid=0, garbage_apply=0, busy=0.
  - The previous-lock-cleared flag is also 0.
- Lock sampled at edge 0 gives EVAL in cycle 1.
  - lines_cleared, combo_count and b2b_active update at edge 1→2.
- CANCEL is cycle 2.
  - send_valid is first high in cycle 3, or garbage_apply pulses in cycle 2 for an n==0 lock.
- send_valid stays high until the handshake.
  - lines_sent updates on the edge following the handshake, and busy drops in the same cycle.
- Minimum lock-to-lock spacing without overrun:
  - 3 cycles for zero-attack or apply paths.
  - 4 cycles plus ready stall when sending.
- Reset asserted mid-SEND drops send_valid asynchronously; no partial send is counted.

## Test plan
- Reset, then a non-T-spin tetris lock (4 rows full) with pending 0 -> lines_cleared=4, combo 0, b2b_active=1, send_count=4 in cycle 3; lines_sent=4 after ready.
- Second tetris immediately after the first -> combo 1, attack 4+1+1=6, lines_sent=10.
- pending_garbage=5, then a T-spin double (attack 4) -> pending 1, no send_valid; next zero-line lock -> garbage_apply count 1, pending 0.
- pending 7, zero-line lock with APPLY_MAX=4 -> apply 4, pending 3; garbage_in 2 arriving in the apply cycle -> pending 5.
- send_ready held low 10 cycles with send_valid up -> send_count stable; a lock during the stall is dropped and lock_overrun=1; game_start -> everything 0 and IDLE.
- Saturation: combo driven to 31 holds at 31 with bonus 5; garbage_in_count 31 twice -> pending 31; lines_cleared wraps 1023+1 -> 0.
